// File: rtl/ddr4_pkg.sv
// Shared definitions for the DDR4 power-up initialization sequencer:
// command encodings, the init state enum and the mode-register issue order.
package ddr4_pkg;

  localparam int unsigned CMD_W  = 5;
  localparam int unsigned TMR_W  = 16;
  localparam int unsigned MR_CNT = 7;
  localparam int unsigned A_W    = 14;

  // {CS_n, ACT_n, RAS_n, CAS_n, WE_n}
  typedef logic [CMD_W-1:0] cmd_t;

  localparam cmd_t CMD_DES  = 5'b11111;
  localparam cmd_t CMD_MRS  = 5'b01000;
  localparam cmd_t CMD_ZQCL = 5'b01110;

  localparam logic [A_W-1:0] ZQCL_A = 14'h0400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_HOLD,
    ST_CKE_WAIT,
    ST_XPR,
    ST_MRS,
    ST_ZQ,
    ST_DONE
  } init_state_e;

  // JEDEC mode-register write order; element 0 is issued first
  localparam logic [0:MR_CNT-1][2:0] MR_ORDER = {3'd3, 3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0};

endpackage

// File: rtl/ddr4_init_seq_if.sv
// Controller handshake plus DRAM reset/CKE/command bus driven by ddr4_init_seq.
interface ddr4_init_seq_if;
  logic        init_start;
  logic        RESET_n;
  logic        CKE;
  logic        CS_n;
  logic        ACT_n;
  logic        RAS_n;
  logic        CAS_n;
  logic        WE_n;
  logic [1:0]  BG;
  logic [1:0]  BA;
  logic [13:0] A;
  logic        init_busy;
  logic        init_done;

  modport master (
    input  init_start,
    output RESET_n, CKE, CS_n, ACT_n, RAS_n, CAS_n, WE_n, BG, BA, A,
    output init_busy, init_done
  );

  modport slave (
    output init_start,
    input  RESET_n, CKE, CS_n, ACT_n, RAS_n, CAS_n, WE_n, BG, BA, A,
    input  init_busy, init_done
  );
endinterface

// File: rtl/ddr4_wait_timer.sv
// 16-bit loadable down-counter shared by every wait in the init sequence.
module ddr4_wait_timer
  import ddr4_pkg::*;
(
  input  logic             CK_t,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge CK_t) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TMR_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ddr4_init_seq.sv
// DDR4 power-up init sequencer: reset/CKE ramp, seven MRS writes, optional ZQCL.
// Define DDR4_ZQCAL_EN to include the ZQ calibration state.
module ddr4_init_seq
  import ddr4_pkg::*;
#(
  parameter int unsigned     T_RESET  = 20,
  parameter int unsigned     T_CKE    = 50,
  parameter int unsigned     T_XPR    = 10,
  parameter int unsigned     T_MRD    = 8,
  parameter int unsigned     T_MOD    = 10,
  parameter int unsigned     T_ZQINIT = 32,
  parameter logic [A_W-1:0]  MR0_VAL  = 14'h0000,
  parameter logic [A_W-1:0]  MR1_VAL  = 14'h0000,
  parameter logic [A_W-1:0]  MR2_VAL  = 14'h0000,
  parameter logic [A_W-1:0]  MR3_VAL  = 14'h0000,
  parameter logic [A_W-1:0]  MR4_VAL  = 14'h0000,
  parameter logic [A_W-1:0]  MR5_VAL  = 14'h0000,
  parameter logic [A_W-1:0]  MR6_VAL  = 14'h0000
)(
  input  logic            CK_t,
  input  logic            rst,
  ddr4_init_seq_if.master bus
);

  // A zero delay is illegal; such a build never leaves IDLE
  localparam bit PARAMS_OK = (T_RESET != 0) && (T_CKE != 0) && (T_XPR != 0) &&
                             (T_MRD != 0) && (T_MOD != 0) && (T_ZQINIT != 0);
  localparam logic [2:0] LAST_IDX = 3'(MR_CNT - 1);

  function automatic logic [A_W-1:0] mr_payload(input logic [2:0] mr);
    case (mr)
      3'd0:    mr_payload = MR0_VAL;
      3'd1:    mr_payload = MR1_VAL;
      3'd2:    mr_payload = MR2_VAL;
      3'd3:    mr_payload = MR3_VAL;
      3'd4:    mr_payload = MR4_VAL;
      3'd5:    mr_payload = MR5_VAL;
      3'd6:    mr_payload = MR6_VAL;
      default: mr_payload = '0;
    endcase
  endfunction

  init_state_e      state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       mr_sel;
  logic             issue_mrs;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;

  cmd_t             cmd_q, cmd_d;
  logic [1:0]       bg_q, bg_d, ba_q, ba_d;
  logic [A_W-1:0]   a_q, a_d;
  logic             reset_n_q, reset_n_d, cke_q, cke_d;
  logic             busy_q, busy_d, done_q, done_d;

  ddr4_wait_timer u_timer (
    .CK_t     (CK_t),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // State and registered bus outputs
  always_ff @(posedge CK_t) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cmd_q     <= CMD_DES;
      bg_q      <= '0;
      ba_q      <= '0;
      a_q       <= '0;
      reset_n_q <= 1'b0;
      cke_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cmd_q     <= cmd_d;
      bg_q      <= bg_d;
      ba_q      <= ba_d;
      a_q       <= a_d;
      reset_n_q <= reset_n_d;
      cke_q     <= cke_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next state, timer loads and the value each output takes next cycle
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    issue_mrs = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    cmd_d     = CMD_DES;
    bg_d      = '0;
    ba_d      = '0;
    a_d       = '0;

    if (state_q != ST_IDLE && !bus.init_start) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.init_start && PARAMS_OK) begin
            state_d  = ST_RST_HOLD;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(T_RESET - 1);
          end
        end
        ST_RST_HOLD: begin
          if (tmr_zero) begin
            state_d  = ST_CKE_WAIT;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(T_CKE - 1);
          end
        end
        ST_CKE_WAIT: begin
          if (tmr_zero) begin
            state_d  = ST_XPR;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(T_XPR - 1);
          end
        end
        ST_XPR: begin
          if (tmr_zero) begin
            state_d   = ST_MRS;
            idx_d     = '0;
            issue_mrs = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = TMR_W'(T_MRD - 1);
          end
        end
        ST_MRS: begin
          if (tmr_zero) begin
            if (idx_q == LAST_IDX) begin
`ifdef DDR4_ZQCAL_EN
              state_d  = ST_ZQ;
              tmr_load = 1'b1;
              tmr_val  = TMR_W'(T_ZQINIT - 1);
              cmd_d    = CMD_ZQCL;
              a_d      = ZQCL_A;
`else
              state_d  = ST_DONE;
`endif
            end else begin
              idx_d     = idx_q + 3'd1;
              issue_mrs = 1'b1;
              tmr_load  = 1'b1;
              // the MR0 slot is followed by tMOD rather than tMRD
              tmr_val   = (idx_d == LAST_IDX) ? TMR_W'(T_MOD - 1) : TMR_W'(T_MRD - 1);
            end
          end
        end
        ST_ZQ: begin
          if (tmr_zero) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    mr_sel = MR_ORDER[idx_d];
    if (issue_mrs) begin
      cmd_d = CMD_MRS;
      bg_d  = {1'b0, mr_sel[2]};
      ba_d  = mr_sel[1:0];
      a_d   = mr_payload(mr_sel);
    end

    reset_n_d = (state_d != ST_IDLE) && (state_d != ST_RST_HOLD);
    cke_d     = (state_d == ST_XPR) || (state_d == ST_MRS) ||
                (state_d == ST_ZQ)  || (state_d == ST_DONE);
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d    = (state_d == ST_DONE);
  end

  assign bus.RESET_n   = reset_n_q;
  assign bus.CKE       = cke_q;
  assign bus.CS_n      = cmd_q[4];
  assign bus.ACT_n     = cmd_q[3];
  assign bus.RAS_n     = cmd_q[2];
  assign bus.CAS_n     = cmd_q[1];
  assign bus.WE_n      = cmd_q[0];
  assign bus.BG        = bg_q;
  assign bus.BA        = ba_q;
  assign bus.A         = a_q;
  assign bus.init_busy = busy_q;
  assign bus.init_done = done_q;

endmodule

// File: tb/tb_ddr4_init_seq.sv
// Self-checking bench for ddr4_init_seq: cycle-accurate milestone model with
// randomized abort/reset points and idle gaps.
module tb_ddr4_init_seq;

  localparam int T_RESET  = 20;
  localparam int T_CKE    = 50;
  localparam int T_XPR    = 10;
  localparam int T_MRD    = 8;
  localparam int T_MOD    = 10;
  localparam int T_ZQINIT = 32;
`ifdef DDR4_ZQCAL_EN
  localparam bit ZQ_EN = 1'b1;
`else
  localparam bit ZQ_EN = 1'b0;
`endif

  localparam int MR_SEQ [7] = '{3, 6, 5, 4, 2, 1, 0};
  localparam int T_RN    = T_RESET;
  localparam int T_CKE_R = T_RESET + T_CKE;
  localparam int T_MR_1  = T_CKE_R + T_XPR;
  localparam int T_ZQ    = T_MR_1 + 6 * T_MRD + T_MOD;
  localparam int T_DONE  = T_ZQ + (ZQ_EN ? T_ZQINIT : 0);

  // {RESET_n, CKE, CS_n, ACT_n, RAS_n, CAS_n, WE_n, BG, BA, A, init_busy, init_done}
  localparam logic [26:0] RST_VAL = {2'b00, 5'b11111, 2'b00, 2'b00, 14'h0000, 2'b00};

  logic CK_t = 1'b0;
  logic rst  = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [26:0] obs;

  always #5 CK_t = ~CK_t;

  ddr4_init_seq_if bus ();

  ddr4_init_seq #(
    .T_RESET (T_RESET), .T_CKE (T_CKE), .T_XPR (T_XPR), .T_MRD (T_MRD),
    .T_MOD (T_MOD), .T_ZQINIT (T_ZQINIT),
    .MR0_VAL (14'h0100), .MR1_VAL (14'h0101), .MR2_VAL (14'h0102),
    .MR3_VAL (14'h0103), .MR4_VAL (14'h0104), .MR5_VAL (14'h0105),
    .MR6_VAL (14'h0106)
  ) dut (
    .CK_t (CK_t),
    .rst  (rst),
    .bus  (bus)
  );

  always_comb obs = {bus.RESET_n, bus.CKE, bus.CS_n, bus.ACT_n, bus.RAS_n, bus.CAS_n,
                     bus.WE_n, bus.BG, bus.BA, bus.A, bus.init_busy, bus.init_done};

  // Expected bus at cycle c of an uninterrupted sequence
  function automatic logic [26:0] exp_at(input int c);
    logic [4:0]  cmd = 5'b11111;
    logic [1:0]  bg  = 2'b00;
    logic [1:0]  ba  = 2'b00;
    logic [13:0] a   = 14'h0000;
    for (int k = 0; k < 7; k++) begin
      if (c == T_MR_1 + k * T_MRD) begin
        cmd = 5'b01000;
        bg  = 2'(MR_SEQ[k] / 4);
        ba  = 2'(MR_SEQ[k] % 4);
        a   = 14'(32'h0100 + MR_SEQ[k]);
      end
    end
    if (ZQ_EN && c == T_ZQ) begin
      cmd = 5'b01110;
      a   = 14'h0400;
    end
    return {(c >= T_RN), (c >= T_CKE_R), cmd, bg, ba, a, (c < T_DONE), (c >= T_DONE)};
  endfunction

  task automatic tick();
    @(posedge CK_t);
    #1;
  endtask

  task automatic check(input string tag, input int c, input logic [26:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, obs, expv);
    end
  endtask

  // Caller has set init_start=1 in IDLE; the first tick lands on cycle 0
  task automatic run_seq(input string tag, input int last);
    for (int c = 0; c <= last; c++) begin
      tick();
      check(tag, c, exp_at(c));
    end
  endtask

  task automatic idle_gap(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, i, RST_VAL);
    end
  endtask

  initial begin
    int cut;
    bus.init_start = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("reset", 0, RST_VAL);
    rst = 1'b0;
    idle_gap("idle", int'($urandom_range(2, 6)));

    // full sequence, dwell in DONE, then release
    bus.init_start = 1'b1;
    run_seq("full", T_DONE + int'($urandom_range(1, 5)));
    bus.init_start = 1'b0;
    tick();
    check("done_drop", 0, RST_VAL);
    idle_gap("idle_after_done", 2);

    // abort mid-MRS at cycle 100, then restart
    bus.init_start = 1'b1;
    run_seq("pre_abort", 100);
    bus.init_start = 1'b0;
    tick();
    check("abort100", 0, RST_VAL);
    bus.init_start = 1'b1;
    run_seq("restart", T_DONE + 1);
    bus.init_start = 1'b0;
    tick();
    check("done_drop2", 0, RST_VAL);

    // abort at a random cycle
    cut = int'($urandom_range(1, T_DONE - 1));
    bus.init_start = 1'b1;
    run_seq("pre_rand_abort", cut);
    bus.init_start = 1'b0;
    tick();
    check("rand_abort", cut, RST_VAL);
    idle_gap("idle_rand", int'($urandom_range(0, 4)));

    // rst at cycle 60 with init_start held
    bus.init_start = 1'b1;
    run_seq("pre_rst60", 60);
    rst = 1'b1;
    tick();
    check("rst60", 0, RST_VAL);
    idle_gap("rst60_hold", int'($urandom_range(0, 3)));
    rst = 1'b0;
    run_seq("after_rst60", T_DONE);

    // rst at a random point within the MRS window
    rst = 1'b1;
    tick();
    check("rst_in_done", 0, RST_VAL);
    rst = 1'b0;
    cut = int'($urandom_range(T_MR_1, T_MR_1 + 6 * T_MRD));
    run_seq("pre_rst_mrs", cut);
    rst = 1'b1;
    tick();
    check("rst_mrs", cut, RST_VAL);
    rst = 1'b0;
    run_seq("after_rst_mrs", T_DONE + 2);
    bus.init_start = 1'b0;
    tick();
    check("final_drop", 0, RST_VAL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
